// File: rtl/conv_buf_pkg.sv
// conv_buf_pkg: shared types and lane-packing helpers for the ping/pong conv tile buffer.
package conv_buf_pkg;
    localparam int CPLX_DW = 32;
    localparam int LANE_W = 2 * CPLX_DW;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} half_state_t;
    typedef struct packed {
        logic [CPLX_DW-1:0] r;
        logic [CPLX_DW-1:0] i;
    } complex_t;
    // Real part sits in the upper half of a lane, imaginary in the lower.
    function automatic logic [LANE_W-1:0] pack_lane(input complex_t c);
        return {c.r, c.i};
    endfunction
    function automatic complex_t unpack_lane(input logic [LANE_W-1:0] w);
        return complex_t'(w);
    endfunction
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM, one write port and one registered read port.
module dual_port_ram #(
    parameter int WIDTH = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/pingpong_half_ctrl.sv
// pingpong_half_ctrl: per-half fill/read state, write pointer and fill lengths for the ping/pong buffer.
module pingpong_half_ctrl
    import conv_buf_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic              wr_last,
    input  logic              rd_en,
    input  logic              rd_release,
    output logic              wr_ready,
    output logic              wr_fire,
    output logic              wr_half,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              rd_half,
    output logic              rd_avail,
    output logic              rd_fire,
    output logic [ADDR_W:0]   rd_len
);
    half_state_t state [2];
    half_state_t state_n [2];
    logic [ADDR_W:0] fill_len [2];
    logic [ADDR_W:0] fill_len_n [2];
    logic wr_half_n, rd_half_n, close;
    logic [ADDR_W-1:0] wr_ptr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= '{EMPTY, EMPTY};
            fill_len <= '{default: '0};
            wr_half  <= 1'b0;
            rd_half  <= 1'b0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_n;
            fill_len <= fill_len_n;
            wr_half  <= wr_half_n;
            rd_half  <= rd_half_n;
            wr_ptr   <= wr_ptr_n;
        end
    end

    always_comb begin
        state_n    = state;
        fill_len_n = fill_len;
        wr_half_n  = wr_half;
        rd_half_n  = rd_half;
        wr_ptr_n   = wr_ptr;
        wr_ready   = !reset && (state[wr_half] == EMPTY || state[wr_half] == FILLING);
        rd_avail   = state[rd_half] == FULL || state[rd_half] == READING;
        rd_len     = rd_avail ? fill_len[rd_half] : '0;
        wr_fire    = wr_valid && wr_ready;
        rd_fire    = rd_en && rd_avail;
        // The last address always closes the half so the pointer never wraps inside a tile.
        close      = wr_last || (&wr_ptr);
        if (wr_fire) begin
            state_n[wr_half]    = close ? FULL : FILLING;
            fill_len_n[wr_half] = close ? (ADDR_W+1)'(wr_ptr) + (ADDR_W+1)'(1) : fill_len[wr_half];
            wr_half_n           = close ? !wr_half : wr_half;
            wr_ptr_n            = close ? '0 : wr_ptr + ADDR_W'(1);
        end
        if (rd_fire && state[rd_half] == FULL) state_n[rd_half] = READING;
        if (rd_release && rd_avail) begin
            state_n[rd_half] = EMPTY;
            rd_half_n        = !rd_half;
        end
    end
endmodule

// File: rtl/conv_pingpong_buffer.sv
// conv_pingpong_buffer: double-buffered complex tile store between the cacheline loader and conv MAC array.
// Define CONV_BUF_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module conv_pingpong_buffer
    import conv_buf_pkg::*;
#(
    parameter int NUM_LANES = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [NUM_LANES*2*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_LANES-1:0]              wr_lane_mask,
    input  logic                              wr_last,
    output logic                              rd_avail,
    output logic [ADDR_W:0]                   rd_len,
    input  logic                              rd_en,
    input  logic [ADDR_W-1:0]                 rd_addr,
    input  logic                              rd_release,
    output logic                              rd_valid,
    output logic [NUM_LANES*2*DATA_WIDTH-1:0] rd_data
);
    localparam int LW = 2 * DATA_WIDTH;
    logic wr_fire, rd_fire, wr_half, rd_half;
    logic [ADDR_W-1:0] wr_ptr;
    logic [NUM_LANES*LW-1:0] ram_q, rd_q;
    logic rd_valid_q, rd_zero_q;

    pingpong_half_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ctrl (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_last(wr_last),
        .rd_en(rd_en),
        .rd_release(rd_release),
        .wr_ready(wr_ready),
        .wr_fire(wr_fire),
        .wr_half(wr_half),
        .wr_ptr(wr_ptr),
        .rd_half(rd_half),
        .rd_avail(rd_avail),
        .rd_fire(rd_fire),
        .rd_len(rd_len)
    );

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        dual_port_ram #(.WIDTH(LW), .ADDR_W(ADDR_W + 1)) u_ram (
            .clk(clk),
            .we(wr_fire && wr_lane_mask[k]),
            .waddr({wr_half, wr_ptr}),
            .wdata(wr_data[k*LW +: LW]),
            .re(rd_fire),
            .raddr({rd_half, rd_addr}),
            .rdata(ram_q[k*LW +: LW])
        );
    end

    // The zero flag shadows the RAM read register so out-of-range reads and reset both present zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_zero_q <= {1'b0, rd_addr} >= rd_len;
        end
    end

    assign rd_q = rd_zero_q ? '0 : ram_q;

`ifdef CONV_BUF_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_valid_q;
            rd_data  <= rd_q;
        end
    end
`else
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_q;
`endif
endmodule
